// File: rtl/copy_pkg.sv
// Shared types and constants for the copy_n fan-out stage.
package copy_pkg;
  localparam int RETIRED_W = 16;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_OUT = 4;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {EMPTY, BCAST} head_state_e;

  // Packed FIFO entry is {mask, data}
  function automatic int entryW(input int dataW, input int nOut);
    return dataW + nOut;
  endfunction
endpackage

// File: rtl/copy_fifo.sv
// Synchronous DEPTH-entry FIFO; the caller never pushes when full or pops when empty.
module copy_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int FILL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [W-1:0]      pushData,
  input  logic              pop,
  output logic [W-1:0]      headData,
  output logic [FILL_W-1:0] fill
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [PTR_W-1:0]        wrPtr, rdPtr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem   <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      fill  <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      if (pop) rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  assign headData = mem[rdPtr];
endmodule

// File: rtl/copy_n.sv
// Buffered N-way copy stage: each head token is offered to every masked output,
// each output handshakes independently, and the head pops once all have taken it.
module copy_n import copy_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_OUT = DEF_N_OUT,
  parameter int DEPTH = DEF_DEPTH,
  localparam int FILL_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [N_OUT-1:0]     in_mask,
  output logic [N_OUT-1:0]     out_valid,
  input  logic [N_OUT-1:0]     out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [FILL_W-1:0]    fill,
  output logic [RETIRED_W-1:0] retired
);
  localparam int ENTRY_W = entryW(WIDTH, N_OUT);

  typedef struct packed {
    logic [N_OUT-1:0] mask;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t           pushEntry, headEntry;
  head_state_e      state, stateNxt;
  logic [N_OUT-1:0] sent, sentNxt, fire, done;
  logic             push, pop, isBcast;

  assign pushEntry = '{mask: in_mask, data: in_data};
  // Full is judged on registered fill only, so a same-cycle pop never frees a slot
  assign in_ready  = (fill < FILL_W'(DEPTH));
  assign push      = in_valid & in_ready;

  copy_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) uFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pushData (pushEntry),
    .pop      (pop),
    .headData (headEntry),
    .fill     (fill)
  );

  assign isBcast = (state == BCAST);

  for (genvar i = 0; i < N_OUT; i++) begin : gLane
    assign out_valid[i] = isBcast & headEntry.mask[i] & ~sent[i];
    assign fire[i]      = out_valid[i] & out_ready[i];
  end

  assign done     = headEntry.mask & ~(sent | fire);
  assign out_data = isBcast ? headEntry.data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      sent    <= '0;
      retired <= '0;
    end else begin
      state <= stateNxt;
      sent  <= sentNxt;
      if (pop) retired <= retired + RETIRED_W'(1);
    end
  end

  always_comb begin
    stateNxt = state;
    sentNxt  = sent;
    pop      = 1'b0;
    case (state)
      EMPTY: if (push) stateNxt = BCAST;
      BCAST: begin
        if (done == '0) begin
          pop     = 1'b1;
          sentNxt = '0;
          if (fill == FILL_W'(1) && !push) stateNxt = EMPTY;
        end else begin
          sentNxt = sent | fire;
        end
      end
      default: stateNxt = EMPTY;
    endcase
  end
endmodule

// File: tb/tb_copy_n.sv
// Directed bench for copy_n with WIDTH=8, N_OUT=4, DEPTH=4.
module tb_copy_n;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [3:0]  in_mask;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  out_data;
  logic [2:0]  fill;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

  copy_n #(.WIDTH(8), .N_OUT(4), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fill      (fill),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; out_ready = '0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_fill", fill, 0);
    check("rst_retired", retired, 0);
    #1 reset = 1'b0;
    step();

    // basic broadcast
    in_valid = 1; in_data = 8'h5A; in_mask = 4'b1111; out_ready = 4'b1111;
    step();
    in_valid = 0;
    check("bc_valid", out_valid, 4'b1111);
    check("bc_data", out_data, 8'h5A);
    check("bc_fill", fill, 1);
    check("bc_ret0", retired, 0);
    step();
    check("bc_valid_off", out_valid, 0);
    check("bc_ret1", retired, 1);
    check("bc_fill0", fill, 0);

    // staggered consumer on output 2
    in_valid = 1; in_data = 8'hA5; in_mask = 4'b1111; out_ready = 4'b1011;
    step();
    in_valid = 0;
    check("st_c1_valid", out_valid, 4'b1111);
    step();
    check("st_c2_valid", out_valid, 4'b0100);
    check("st_c2_data", out_data, 8'hA5);
    for (int i = 3; i <= 5; i++) begin
      step();
      check($sformatf("st_c%0d_valid", i), out_valid, 4'b0100);
    end
    step();
    out_ready = 4'b1111;
    check("st_c6_valid", out_valid, 4'b0100);
    check("st_c6_ret", retired, 1);
    step();
    check("st_done_valid", out_valid, 0);
    check("st_done_ret", retired, 2);

    // selective and zero mask, back to back
    in_valid = 1; in_data = 8'h11; in_mask = 4'b0101;
    step();
    in_data = 8'h22; in_mask = 4'b0000;
    check("sel_11_valid", out_valid, 4'b0101);
    check("sel_11_data", out_data, 8'h11);
    step();
    in_data = 8'h33; in_mask = 4'b1000;
    check("sel_22_valid", out_valid, 0);
    check("sel_22_fill", fill, 1);
    step();
    in_valid = 0;
    check("sel_33_valid", out_valid, 4'b1000);
    check("sel_33_data", out_data, 8'h33);
    step();
    check("sel_ret", retired, 5);
    check("sel_fill", fill, 0);

    // full / backpressure
    out_ready = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1; in_data = 8'h40 + 8'(k); in_mask = 4'b1111;
      check($sformatf("full_rdy%0d", k), in_ready, (k < 4) ? 1 : 0);
      step();
    end
    check("full_fill", fill, 4);
    in_data = 8'h99; out_ready = 4'b1111;
    check("full_pop_rdy", in_ready, 0);
    check("full_head40", out_data, 8'h40);
    step();
    in_valid = 0;
    check("drain_rdy", in_ready, 1);
    check("drain_fill3", fill, 3);
    check("drain_head41", out_data, 8'h41);
    step();
    check("drain_head42", out_data, 8'h42);
    check("drain_fill2", fill, 2);
    step();
    check("drain_head43", out_data, 8'h43);
    check("drain_fill1", fill, 1);
    step();
    check("drain_empty_valid", out_valid, 0);
    check("drain_fill0", fill, 0);
    check("drain_ret", retired, 9);

    // reset mid-token
    out_ready = 4'b0000;
    in_valid = 1; in_data = 8'h61; in_mask = 4'b1111;
    step();
    in_data = 8'h62;
    step();
    in_valid = 0; out_ready = 4'b0001;
    check("mr_valid_pre", out_valid, 4'b1111);
    step();
    out_ready = 4'b0000;
    check("mr_partial_valid", out_valid, 4'b1110);
    check("mr_fill2", fill, 2);
    #3 reset = 1'b1;
    #1;
    check("mr_rst_valid", out_valid, 0);
    check("mr_rst_fill", fill, 0);
    check("mr_rst_ret", retired, 0);
    check("mr_rst_rdy", in_ready, 1);
    #1 reset = 1'b0;
    step();
    in_valid = 1; in_data = 8'h7E; in_mask = 4'b0110; out_ready = 4'b1111;
    step();
    in_valid = 0;
    check("mr_new_valid", out_valid, 4'b0110);
    check("mr_new_data", out_data, 8'h7E);
    step();
    check("mr_new_ret", retired, 1);
    check("mr_new_valid_off", out_valid, 0);

    // counter wrap with zero-mask tokens
    in_valid = 1; in_data = 8'h00; in_mask = 4'b0000;
    for (int n = 0; n < 65535; n++) step();
    in_valid = 0;
    check("wrap_ffff", retired, 16'hFFFF);
    check("wrap_fill1", fill, 1);
    check("wrap_no_valid", out_valid, 0);
    step();
    check("wrap_zero", retired, 0);
    check("wrap_fill0", fill, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/copy_n.md
# copy_n

Parametrised, clocked N-way copy (fork) stage for channel-based designs. Each token accepted on the input channel is buffered in a DEPTH-entry FIFO, then delivered to every output selected by a per-token mask. Each output channel completes its handshake independently, so a slow consumer does not stall delivery to the others. The block sits wherever one producer feeds several consumers and replaces the fixed four-way copy with a configurable fan-out that has buffering and selective routing.

## Interface
- WIDTH, 8: token data width in bits.
- N_OUT, 4: number of output channels, 2..16.
- DEPTH, 4: input FIFO depth in entries; power of two, at least 2.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer offers a token.
- in_ready  output  1  FIFO can accept a token.
- in_data  input  WIDTH  token payload.
- in_mask  input  N_OUT  bit i set means the token goes to output i.
- out_valid  output  N_OUT  per-output token offer.
- out_ready  input  N_OUT  per-output consumer acceptance.
- out_data  output  WIDTH  head-token payload, shared by all outputs.
- fill  output  $clog2(DEPTH+1)  number of tokens currently buffered.
- retired  output  16  count of tokens fully delivered; wraps modulo 2^16.

## Operation
- Push: when in_valid & in_ready, the pair {in_mask, in_data} is written at the FIFO tail.
- in_ready = (fill < DEPTH). It depends only on registered state, with no combinational path from out_ready.
- Head state:
  - EMPTY when fill == 0.
  - BCAST otherwise, with a registered sent[N_OUT] vector tracking which outputs have already taken the head token.
- out_valid[i] = BCAST & mask[i] & ~sent[i].
- out_data = head data, held stable while any out_valid bit is high.
- Output i fires on out_valid[i] & out_ready[i].
- done = mask & ~(sent | fire).
- When done == 0:
  - the head is popped,
  - sent clears to 0,
  - retired increments,
  - the state moves to EMPTY if this was the last entry, otherwise it stays in BCAST on the next entry.
- When done != 0: sent <= sent | fire.
- Mask of zero: the token is retired in its first head cycle with no output activity, and retired still increments.
- Push and pop in the same cycle: fill stays unchanged. The full condition is checked before the pop, so a full FIFO refuses the push even if it pops in that cycle.
- Reset mid-operation: all buffered tokens and partial deliveries are discarded, with no completion of the in-flight token.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, fill=0, retired=0, sent=0, FIFO pointers=0.
- Latency: a token pushed at edge t into an empty FIFO raises its out_valid bits after edge t, i.e. it is visible during cycle t+1. There is no combinational input-to-output bypass.
- Throughput: one token per cycle when all selected outputs are ready.
- Output valid rules:
  - out_valid[i], once high, stays high until it fires.
  - It never re-asserts for the same token.
- Pointer and counter widths:
  - FIFO pointers are $clog2(DEPTH) bits and wrap naturally.
  - fill is $clog2(DEPTH+1) bits and ranges 0..DEPTH.
  - retired is 16 bits; 0xFFFF+1 gives 0x0000.

## Structure
- Package copy_pkg holds:
  - the head_state_e enum (EMPTY, BCAST),
  - the entry struct packing {mask, data}, defined as a parameterised typedef where the tool allows, otherwise as explicit width localparams,
  - the RETIRED_W=16 constant.
- Sub-module copy_fifo is a synchronous DEPTH×(N_OUT+WIDTH) FIFO with push, pop, head, fill, and async reset.
- copy_n wraps copy_fifo and adds the head/sent broadcast logic and the retired counter.

## Test plan
- Basic broadcast: N_OUT=4, mask=4'b1111, data=0x5A, all out_ready=1 → all four out_valid high for one cycle at t+1, each with out_data=0x5A; retired goes 0→1.
- Staggered consumers: mask=1111, out_ready held 0 on output 2 for 5 cycles, others ready → outputs 0, 1, 3 fire in cycle 1; output 2 fires in cycle 6; pop in cycle 6; no duplicate valid on any output.
- Selective and zero mask: tokens 0x11 mask=0101, 0x22 mask=0000, 0x33 mask=1000 → only outputs 0 and 2 see 0x11, nobody sees 0x22, only output 3 sees 0x33; retired=3.
- Full/backpressure: DEPTH=4, all out_ready=0, push 6 tokens → 4 accepted, then in_ready=0 and fill=4. Releasing out_ready drains them in order; in_ready does not rise in the same cycle as the first pop.
- Reset mid-token: 2 tokens buffered, one output of the head already sent, assert reset asynchronously → out_valid=0, fill=0, retired=0 immediately; after release, a new token 0x7E is delivered cleanly to all masked outputs.
- Counter wrap: preset via 65536 zero-mask tokens → retired wraps to 0 and fill returns to 0.
